// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants for the memory controller.
//   - instruction type codes seen on lsb_type (load / store)
//   - funct3 access-size field encodings and load-extension ops
//   - IO window selector (address bits [17:16] == 2'b11, i.e. >= 0x30000)
//   - controller state encoding and an access-size helper
package mem_ctrl_pkg;

  localparam logic [6:0] LD_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;

  // op[1:0] access size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // full funct3 load ops
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  // Number of bytes moved for a given access size.
  function automatic logic [2:0] acc_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// mem_ext: load-result extension (purely combinational).
//   op     - funct3 of the load
//   raw    - assembled little-endian word (only low bytes meaningful for B/H)
//   result - sign/zero extended 32-bit load value
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (op)
      OP_LB:   result = {{24{raw[7]}},  raw[7:0]};
      OP_LH:   result = {{16{raw[15]}}, raw[15:0]};
      OP_LW:   result = raw;
      OP_LBU:  result = {24'd0, raw[7:0]};
      OP_LHU:  result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating LSB data accesses and
// instruction fetch onto a single 8-bit RAM port.
//   clk, rst (sync, active-high), rdy (low = freeze), rob_clear (flush)
//   lsb_*  : load/store request in, accept/done/type/rdata out
//   if_*   : fetch request in, done/instr out
//   mem_*  : RAM port (address, write strobe, write byte, read byte with
//            one cycle latency); io_buffer_full stalls IO stores
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,

  input  logic        lsb_valid,
  input  logic [2:0]  lsb_op,
  input  logic [6:0]  lsb_type,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_accept,
  output logic        lsb_done,
  output logic [6:0]  lsb_type_out,
  output logic [31:0] lsb_rdata,

  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_instr,

  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;       // active cycles spent in current state
  logic [2:0]  len_q, len_d;       // bytes in this access
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;     // bytes assembled so far
  logic [2:0]  op_q, op_d;
  logic [6:0]  type_q, type_d;

  logic        lsb_done_q, lsb_done_d;
  logic        if_done_q, if_done_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [6:0]  lsb_type_out_q, lsb_type_out_d;

  // The RAM keeps running while rdy is low, so mem_din moves on to the
  // frozen address. Keep the byte that arrived right after the last active
  // cycle and use it on the first active cycle after rdy returns.
  logic        rdy_prev_q;
  logic [7:0]  din_hold_q;
  logic [7:0]  din_eff;

  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [31:0] ext_word;
  logic        io_stall;

  assign din_eff  = rdy_prev_q ? mem_din : din_hold_q;
  // On cycle cnt, mem_din carries the byte addressed on cycle cnt-1.
  assign byte_idx = cnt_q[1:0] - 2'd1;
  assign io_stall = (state_q == ST_STORE) && (addr_q[17:16] == IO_BASE[17:16])
                    && io_buffer_full;

  always_comb begin
    asm_word = data_q;
    asm_word[{byte_idx, 3'b000} +: 8] = din_eff;
  end

  mem_ext u_ext (
    .op     (op_q),
    .raw    (asm_word),
    .result (ext_word)
  );

  assign lsb_accept   = (state_q == ST_IDLE);
  assign lsb_done     = lsb_done_q;
  assign if_done      = if_done_q;
  assign lsb_rdata    = lsb_rdata_q;
  assign if_instr     = if_instr_q;
  assign lsb_type_out = lsb_type_out_q;

  // next state
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    data_d         = data_q;
    op_d           = op_q;
    type_d         = type_q;
    lsb_done_d     = 1'b0;
    if_done_d      = 1'b0;
    lsb_rdata_d    = lsb_rdata_q;
    if_instr_d     = if_instr_q;
    lsb_type_out_d = lsb_type_out_q;

    case (state_q)
      ST_IDLE: begin
        if (lsb_valid) begin
          case (lsb_type)
            S_TYPE:  state_d = ST_STORE;
            LD_TYPE: state_d = ST_LOAD;
            default: state_d = ST_LOAD;
          endcase
          addr_d  = lsb_addr;
          wdata_d = lsb_wdata;
          op_d    = lsb_op;
          type_d  = lsb_type;
          len_d   = acc_bytes(lsb_op[1:0]);
          cnt_d   = 3'd0;
          data_d  = 32'd0;
        end else if (if_valid) begin
          state_d = ST_FETCH;
          addr_d  = if_addr;
          op_d    = OP_LW;
          len_d   = 3'd4;
          cnt_d   = 3'd0;
          data_d  = 32'd0;
        end
      end

      ST_FETCH, ST_LOAD: begin
        if (rob_clear) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == len_q) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          if (state_q == ST_FETCH) begin
            if_done_d  = 1'b1;
            if_instr_d = asm_word;
          end else begin
            lsb_done_d     = 1'b1;
            lsb_rdata_d    = ext_word;
            lsb_type_out_d = type_q;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) data_d = asm_word;
        end
      end

      ST_STORE: begin
        // committed store: rob_clear deliberately ignored
        if (!io_stall) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d        = ST_IDLE;
            cnt_d          = 3'd0;
            lsb_done_d     = 1'b1;
            lsb_rdata_d    = 32'd0;
            lsb_type_out_d = type_q;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port, decoded from held state so it freezes with rdy
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    case (state_q)
      ST_FETCH, ST_LOAD: begin
        if (cnt_q != len_q) mem_a = addr_q + {29'd0, cnt_q};
      end
      ST_STORE: begin
        mem_a    = addr_q + {29'd0, cnt_q};
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        // rst cuts the byte in flight so reset truly abandons the store
        mem_wr   = rdy && !io_stall && !rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 3'd0;
      len_q          <= 3'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      data_q         <= 32'd0;
      op_q           <= 3'd0;
      type_q         <= 7'd0;
      lsb_done_q     <= 1'b0;
      if_done_q      <= 1'b0;
      lsb_rdata_q    <= 32'd0;
      if_instr_q     <= 32'd0;
      lsb_type_out_q <= 7'd0;
    end else if (rdy) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      data_q         <= data_d;
      op_q           <= op_d;
      type_q         <= type_d;
      lsb_done_q     <= lsb_done_d;
      if_done_q      <= if_done_d;
      lsb_rdata_q    <= lsb_rdata_d;
      if_instr_q     <= if_instr_d;
      lsb_type_out_q <= lsb_type_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_prev_q <= 1'b1;
      din_hold_q <= 8'd0;
    end else begin
      rdy_prev_q <= rdy;
      if (rdy_prev_q) din_hold_q <= mem_din;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl with a byte RAM
// model (1-cycle read latency) and a behavioural load/store/fetch reference.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int RAM_SZ = 1 << 18;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_clear;
  logic        lsb_valid;
  logic [2:0]  lsb_op;
  logic [6:0]  lsb_type;
  logic [31:0] lsb_addr, lsb_wdata;
  logic        lsb_accept, lsb_done;
  logic [6:0]  lsb_type_out;
  logic [31:0] lsb_rdata;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_instr;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic [7:0]  ram [0:RAM_SZ-1];
  logic [31:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];

  int n_vec = 0;
  int n_err = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .lsb_valid(lsb_valid), .lsb_op(lsb_op), .lsb_type(lsb_type),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_accept(lsb_accept), .lsb_done(lsb_done),
    .lsb_type_out(lsb_type_out), .lsb_rdata(lsb_rdata),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_instr(if_instr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // byte RAM: registered read, writes logged in order
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      ram[mem_a[17:0]] = mem_dout;
      wr_a_q.push_back(mem_a);
      wr_d_q.push_back(mem_dout);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // value a load of this op/address should return, from the RAM contents
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    longint v = 0;
    int n = nbytes(op);
    logic [31:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      v = v + (longint'(ram[ak[17:0]]) << (8 * k));
    end
    if (!op[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic wait_done(input bit is_if, input int start, output int lat);
    lat = start;
    while (((is_if ? if_done : lsb_done) !== 1'b1) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic lsb_issue(input logic [2:0] op, input logic [6:0] typ,
                           input logic [31:0] a, input logic [31:0] wd);
    chk("idle_accept", 32'(lsb_accept), 32'd1);
    lsb_valid = 1'b1; lsb_op = op; lsb_type = typ; lsb_addr = a; lsb_wdata = wd;
    @(posedge clk); #1;
    lsb_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] a);
    logic [31:0] exp;
    int lat;
    exp = ref_load(op, a);
    lsb_issue(op, LD_TYPE, a, 32'd0);
    wait_done(1'b0, 0, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(nbytes(op) + 1));
    chk({tag, "_data"}, lsb_rdata, exp);
    chk({tag, "_type"}, 32'(lsb_type_out), 32'(LD_TYPE));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(lsb_done), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input bit clr);
    int lat;
    int n;
    n = nbytes(op);
    wr_a_q.delete(); wr_d_q.delete();
    lsb_issue(op, S_TYPE, a, wd);
    if (clr) begin
      rob_clear = 1'b1;
      @(posedge clk); #1;
      rob_clear = 1'b0;
      wait_done(1'b0, 1, lat);
    end else begin
      wait_done(1'b0, 0, lat);
    end
    chk({tag, "_lat"}, 32'(lat), 32'(n));
    chk({tag, "_nwr"}, 32'(wr_a_q.size()), 32'(n));
    for (int k = 0; k < n && k < wr_a_q.size(); k++) begin
      chk({tag, "_wa"}, wr_a_q[k], a + 32'(k));
      chk({tag, "_wd"}, 32'(wr_d_q[k]), (wd >> (8 * k)) & 32'hFF);
    end
    chk({tag, "_rdata"}, lsb_rdata, 32'd0);
    chk({tag, "_type"}, 32'(lsb_type_out), 32'(S_TYPE));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(lsb_done), 32'd0);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a);
    logic [31:0] exp;
    int lat;
    exp = ref_load(OP_LW, a);
    chk("idle_accept", 32'(lsb_accept), 32'd1);
    if_valid = 1'b1; if_addr = a;
    @(posedge clk); #1;
    if_valid = 1'b0;
    wait_done(1'b1, 0, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_instr"}, if_instr, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(if_done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] ld_ops [5];
    logic [31:0] exp;
    logic [31:0] a;
    int lat;
    bit seen;
    ld_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

    for (int i = 0; i < RAM_SZ; i++) ram[i] = 8'($urandom);
    ram[18'h100] = 8'h80;
    ram[18'h200] = 8'h11; ram[18'h201] = 8'h22; ram[18'h202] = 8'h33; ram[18'h203] = 8'h44;

    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    lsb_valid = 1'b0; lsb_op = 3'd0; lsb_type = 7'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    if_valid = 1'b0; if_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_accept", 32'(lsb_accept), 32'd1);
    chk("rst_lsb_done", 32'(lsb_done), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_rdata", lsb_rdata, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_type", 32'(lsb_type_out), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);

    // byte loads with sign and zero extension
    do_load("lb", OP_LB, 32'h100);
    chk("lb_val", lsb_rdata, 32'hFFFF_FF80);
    do_load("lbu", OP_LBU, 32'h100);
    chk("lbu_val", lsb_rdata, 32'h0000_0080);
    // word load, little-endian assembly
    do_load("lw", OP_LW, 32'h200);
    chk("lw_val", lsb_rdata, 32'h4433_2211);
    // address wrap across 2^32
    do_load("lw_wrap", OP_LW, 32'hFFFF_FFFE);

    // simultaneous store and fetch: store first
    wr_a_q.delete(); wr_d_q.delete();
    lsb_valid = 1'b1; lsb_op = OP_LW; lsb_type = S_TYPE;
    lsb_addr = 32'h300; lsb_wdata = 32'hDEAD_BEEF;
    if_valid = 1'b1; if_addr = 32'h400;
    @(posedge clk); #1;
    lsb_valid = 1'b0;
    wait_done(1'b0, 0, lat);
    chk("arb_st_lat", 32'(lat), 32'd4);
    chk("arb_no_if_done", 32'(if_done), 32'd0);
    chk("arb_nwr", 32'(wr_a_q.size()), 32'd4);
    if (wr_d_q.size() == 4) begin
      chk("arb_bytes", {wr_d_q[0], wr_d_q[1], wr_d_q[2], wr_d_q[3]}, 32'hEFBE_ADDE);
      chk("arb_addr0", wr_a_q[0], 32'h300);
      chk("arb_addr3", wr_a_q[3], 32'h303);
    end
    exp = ref_load(OP_LW, 32'h400);
    @(posedge clk); #1;
    if_valid = 1'b0;
    wait_done(1'b1, 0, lat);
    chk("arb_if_lat", 32'(lat), 32'd5);
    chk("arb_if_instr", if_instr, exp);
    chk("arb_no_lsb_done", 32'(lsb_done), 32'd0);
    @(posedge clk); #1;

    // flush on 2nd cycle of a fetch
    if_valid = 1'b1; if_addr = 32'h440;
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(posedge clk); #1;
    rob_clear = 1'b1;
    @(posedge clk); #1;
    rob_clear = 1'b0;
    chk("flush_idle", 32'(lsb_accept), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      if (if_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 32'(seen), 32'd0);

    // flush during store: store completes
    do_store("st_flush", OP_LW, 32'h600, 32'hCAFE_F00D, 1'b1);

    // IO store with buffer full for three cycles
    io_buffer_full = 1'b1;
    wr_a_q.delete(); wr_d_q.delete();
    lsb_issue(OP_LB, S_TYPE, IO_BASE, 32'h0000_005A);
    for (int i = 0; i < 3; i++) begin
      chk("io_hold_wr", 32'(mem_wr), 32'd0);
      @(posedge clk); #1;
    end
    io_buffer_full = 1'b0;
    #1;
    chk("io_write", 32'(mem_wr), 32'd1);
    @(posedge clk); #1;
    chk("io_done", 32'(lsb_done), 32'd1);
    chk("io_nwr", 32'(wr_a_q.size()), 32'd1);
    if (wr_a_q.size() == 1) begin
      chk("io_addr", wr_a_q[0], IO_BASE);
      chk("io_data", 32'(wr_d_q[0]), 32'h5A);
    end
    @(posedge clk); #1;

    // rdy low for two cycles in the middle of LH
    a = $urandom_range(32'h1000, 32'h2FFF0);
    exp = ref_load(OP_LH, a);
    lsb_issue(OP_LH, LD_TYPE, a, 32'd0);
    @(posedge clk); #1;
    rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done(1'b0, 3, lat);
    chk("rdy_lat", 32'(lat), 32'd5);
    chk("rdy_data", lsb_rdata, exp);
    @(posedge clk); #1;

    // randomized mix
    for (int it = 0; it < 60; it++) begin
      a = $urandom_range(0, 32'h2FFF0);
      case ($urandom_range(0, 4))
        0, 1: do_load("rnd_ld", ld_ops[$urandom_range(0, 4)], a);
        2, 3: do_store("rnd_st", 3'($urandom_range(0, 2)), a, $urandom, 1'($urandom_range(0, 1)));
        default: do_fetch("rnd_if", a);
      endcase
    end

    // reset in the middle of a store abandons remaining bytes
    do_load("pre_rst", OP_LW, 32'h200);
    wr_a_q.delete(); wr_d_q.delete();
    lsb_issue(OP_LW, S_TYPE, 32'h500, 32'h1234_5678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_st_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_st_nwr", 32'(wr_a_q.size()), 32'd2);
    chk("rst_st_idle", 32'(lsb_accept), 32'd1);
    chk("rst_st_rdata", lsb_rdata, 32'd0);
    chk("rst_st_instr", if_instr, 32'd0);
    chk("rst_st_type", 32'(lsb_type_out), 32'd0);
    chk("rst_st_mem_a", mem_a, 32'd0);
    chk("rst_st_dout", 32'(mem_dout), 32'd0);
    do_load("post_rst", OP_LW, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have clk input 1: clock; rst input 1: synchronous, active-high reset; rdy input 1: global enable, low = freeze all state.
REQ-002 SHALL have rob_clear input 1: pipeline flush.
REQ-003 SHALL have lsb_valid input 1, lsb_op input 3 (funct3), lsb_type input 7 (LD_TYPE/S_TYPE), lsb_addr input 32, lsb_wdata input 32: data request from LSB.
REQ-004 SHALL have lsb_accept output 1: idle, request taken this edge; lsb_done output 1: one-cycle completion pulse; lsb_type_out output 7: type of completed request; lsb_rdata output 32: extended load data.
REQ-005 SHALL have if_valid input 1, if_addr input 32: fetch request; if_done output 1: pulse; if_instr output 32: fetched word.
REQ-006 SHALL have mem_din input 8, mem_dout output 8, mem_a output 32, mem_wr output 1 (1 = write): byte-serial RAM port; io_buffer_full input 1.

Function
REQ-007 SHALL implement states IDLE, FETCH, LOAD, STORE; lsb_accept = (state==IDLE), combinational.
REQ-008 SHALL, in IDLE with lsb_valid, enter LOAD or STORE per lsb_type, capturing op/addr/wdata; LSB wins over simultaneous if_valid.
REQ-009 SHALL, in IDLE with only if_valid, enter FETCH, 4 bytes from if_addr.
REQ-010 SHALL size accesses: op[1:0]=00 ->1 byte, 01 ->2, 10 ->4; FETCH always 4.
REQ-011 SHALL drive mem_a = base+k on the k-th active cycle, k=0..n-1; RAM read latency is 1 cycle, byte k sampled from mem_din one cycle later.
REQ-012 SHALL assemble little-endian: byte k into bits [8k+7:8k].
REQ-013 SHALL complete a load/fetch n+1 cycles after entering the state: done pulse on that cycle with data valid, return to IDLE same edge.
REQ-014 SHALL sign-extend loads for op 000/001, zero-extend for op 100/101, pass op 010 unchanged.
REQ-015 SHALL in STORE drive mem_wr=1, mem_dout=wdata byte k, mem_a=addr+k for n cycles; lsb_done pulses the cycle after the last byte, lsb_rdata=0.
REQ-016 SHALL, for store address[17:16]==2'b11 (IO, >=0x30000) with io_buffer_full high, hold the current byte with mem_wr=0 until low.
REQ-017 SHALL keep mem_wr=0 outside STORE and whenever rdy=0; mem_a=0 in IDLE.
REQ-018 SHALL on rob_clear abort FETCH or LOAD to IDLE, no done pulse; STORE SHALL run to completion (stores are committed).
REQ-019 SHALL, on rdy=0, hold state, byte counter, assembled data and outputs; RAM sampling resumes consistently on rdy return.
REQ-020 SHALL ignore lsb_valid/if_valid outside IDLE; done pulses never overlap.
REQ-021 SHALL wrap address arithmetic modulo 2^32.

Reset
REQ-022 SHALL on rst: state IDLE, counter 0, lsb_done=0, if_done=0, lsb_rdata=0, if_instr=0, lsb_type_out=0, mem_wr=0, mem_a=0, mem_dout=0.
REQ-023 SHALL give rst priority over rdy and rob_clear; rst mid-STORE abandons remaining bytes.

Structure
REQ-024 SHALL take LD_TYPE, S_TYPE, access-size encodings and IO base from the shared config constants file.
REQ-025 SHALL place load extension in one combinational sub-module mem_ext (op, raw word -> 32-bit result).

Verification
REQ-026 SHALL test LB op 000, addr 0x100, RAM[0x100]=0x80 -> lsb_done 2 cycles after accept, lsb_rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-027 SHALL test LW addr 0x200, bytes 11 22 33 44 -> lsb_rdata=0x44332211, done 5 cycles after accept.
REQ-028 SHALL test simultaneous lsb_valid (SW 0x300, data 0xDEADBEEF) and if_valid -> STORE first, writes EF BE AD DE to 0x300..0x303, then FETCH.
REQ-029 SHALL test rob_clear on 2nd cycle of FETCH -> IDLE, no if_done; rob_clear during SW -> all 4 bytes written, lsb_done asserted.
REQ-030 SHALL test SB to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low 3 cycles, then one write, lsb_done next cycle.
REQ-031 SHALL test rdy low 2 cycles mid-LH -> result unchanged, done delayed exactly 2 cycles.
